// File: rtl/pst_conv_monitor.sv
// rtl/pst_conv_monitor.sv - gamma-cycle convergence latency monitor for pst_2layer
// Optional macro PST_CONV_STABLE_EN: convergence needs two consecutive in-tolerance samples.
module pst_conv_monitor #(
  parameter logic [7:0] TOL        = 8'd5,
  parameter logic [7:0] MAX_CYC    = 8'd16,
  parameter int         HIST_DEPTH = 8,
  parameter int         HIST_AW    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cycle_start,
  input  logic [7:0]         input_current,
  input  logic [7:0]         error_L2,
  output logic               busy,
  output logic               lat_valid,
  output logic [7:0]         lat_out,
  output logic               timeout,
  output logic [7:0]         trans_count,
  output logic [7:0]         timeout_count,
  output logic [15:0]        sum_lat,
  output logic [HIST_AW:0]   hist_count,
  input  logic [HIST_AW-1:0] hist_rd_idx,
  output logic [8:0]         hist_rd_data
);

  typedef enum logic {IDLE, TRACK} state_t;

  localparam logic [HIST_AW:0] DEPTH_C = (HIST_AW+1)'(HIST_DEPTH);

  state_t             state, state_nxt;
  logic [7:0]         cur_q;
  logic               armed;
  logic [7:0]         cnt, cnt_nxt, cnt_n;
  logic               trans, hit;
  logic               new_trans;
  logic               rec;
  logic [7:0]         rec_lat;
  logic               rec_to;
  logic [HIST_AW-1:0] wr_ptr;
  logic [HIST_AW-1:0] rd_addr;
  logic [8:0]         mem [HIST_DEPTH];
`ifdef PST_CONV_STABLE_EN
  logic               pend, pend_nxt;
`endif

  assign trans = armed && (input_current != cur_q);
  assign hit   = (error_L2 <= TOL);
  assign cnt_n = cnt + 8'd1;
  assign busy  = (state == TRACK);

  // Next-state decision and record request, evaluated only at a sample edge
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    new_trans = 1'b0;
    rec       = 1'b0;
    rec_lat   = 8'd0;
    rec_to    = 1'b0;
`ifdef PST_CONV_STABLE_EN
    pend_nxt  = pend;
`endif
    if (cycle_start) begin
      case (state)
        IDLE: begin
          if (trans) begin
            new_trans = 1'b1;
            cnt_nxt   = 8'd0;
            state_nxt = TRACK;
`ifdef PST_CONV_STABLE_EN
            pend_nxt  = 1'b0;
`endif
          end
        end
        TRACK: begin
          if (trans) begin
            // abort beats the convergence check at this edge
            rec       = 1'b1;
            rec_lat   = cnt;
            rec_to    = 1'b1;
            cnt_nxt   = 8'd0;
            new_trans = 1'b1;
`ifdef PST_CONV_STABLE_EN
            pend_nxt  = 1'b0;
`endif
          end else begin
`ifdef PST_CONV_STABLE_EN
            // cnt already holds the count of the pending first hit
            if (pend && hit) begin
              rec       = 1'b1;
              rec_lat   = cnt;
              state_nxt = IDLE;
              pend_nxt  = 1'b0;
            end else if (cnt_n == MAX_CYC) begin
              rec       = 1'b1;
              rec_lat   = MAX_CYC;
              rec_to    = 1'b1;
              state_nxt = IDLE;
              pend_nxt  = 1'b0;
            end else begin
              cnt_nxt  = cnt_n;
              pend_nxt = hit;
            end
`else
            if (hit) begin
              rec       = 1'b1;
              rec_lat   = cnt_n;
              state_nxt = IDLE;
            end else if (cnt_n == MAX_CYC) begin
              rec       = 1'b1;
              rec_lat   = MAX_CYC;
              rec_to    = 1'b1;
              state_nxt = IDLE;
            end else begin
              cnt_nxt = cnt_n;
            end
`endif
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, statistics and history update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cur_q         <= 8'd0;
      armed         <= 1'b0;
      cnt           <= 8'd0;
      lat_valid     <= 1'b0;
      lat_out       <= 8'd0;
      timeout       <= 1'b0;
      trans_count   <= 8'd0;
      timeout_count <= 8'd0;
      sum_lat       <= 16'd0;
      hist_count    <= '0;
      wr_ptr        <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) mem[i] <= 9'd0;
`ifdef PST_CONV_STABLE_EN
      pend          <= 1'b0;
`endif
    end else begin
      lat_valid <= rec;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
`ifdef PST_CONV_STABLE_EN
      pend      <= pend_nxt;
`endif
      if (cycle_start) begin
        cur_q <= input_current;
        armed <= 1'b1;
      end
      if (new_trans && trans_count != 8'hFF) trans_count <= trans_count + 8'd1;
      if (rec) begin
        lat_out     <= rec_lat;
        timeout     <= rec_to;
        mem[wr_ptr] <= {rec_to, rec_lat};
        wr_ptr      <= wr_ptr + 1'b1;
        if (hist_count != DEPTH_C) hist_count <= hist_count + 1'b1;
        if (sum_lat > (16'hFFFF - {8'd0, rec_lat})) sum_lat <= 16'hFFFF;
        else sum_lat <= sum_lat + {8'd0, rec_lat};
        if (rec_to && timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
      end
    end
  end

  // History read port, index 0 is the newest entry
  always_comb begin
    rd_addr      = wr_ptr - HIST_AW'(1) - hist_rd_idx;
    hist_rd_data = 9'd0;
    if ({1'b0, hist_rd_idx} < hist_count) hist_rd_data = mem[rd_addr];
  end

endmodule

// File: tb/tb_pst_conv_monitor.sv
// tb/tb_pst_conv_monitor.sv - randomized self-checking bench for pst_conv_monitor
module tb_pst_conv_monitor;

  localparam int TOL   = 5;
  localparam int MAXC  = 16;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cycle_start = 1'b0;
  logic [7:0]  input_current = 8'd0;
  logic [7:0]  error_L2 = 8'd0;
  logic [2:0]  hist_rd_idx = 3'd0;
  logic        busy, lat_valid, timeout;
  logic [7:0]  lat_out, trans_count, timeout_count;
  logic [15:0] sum_lat;
  logic [3:0]  hist_count;
  logic [8:0]  hist_rd_data;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit         m_armed, m_track, m_lv, m_to;
  int         m_cur, m_k, m_prev, m_last, m_lat;
  int         m_tc, m_toc, m_sum;
  logic [8:0] hq[$];

  pst_conv_monitor dut (
    .clk(clk), .rst(rst), .cycle_start(cycle_start),
    .input_current(input_current), .error_L2(error_L2),
    .busy(busy), .lat_valid(lat_valid), .lat_out(lat_out), .timeout(timeout),
    .trans_count(trans_count), .timeout_count(timeout_count), .sum_lat(sum_lat),
    .hist_count(hist_count), .hist_rd_idx(hist_rd_idx), .hist_rd_data(hist_rd_data)
  );

  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_armed = 0; m_track = 0; m_lv = 0; m_to = 0;
    m_cur = 0; m_k = 0; m_prev = 0; m_last = 0; m_lat = 0;
    m_tc = 0; m_toc = 0; m_sum = 0;
    hq.delete();
  endtask

  task automatic record(input int lat, input bit to);
    hq.push_front({to, 8'(lat)});
    if (hq.size() > DEPTH) void'(hq.pop_back());
    m_sum = (m_sum + lat > 65535) ? 65535 : m_sum + lat;
    if (to && m_toc < 255) m_toc++;
    m_lv = 1; m_lat = lat; m_to = to;
  endtask

  // one gamma-cycle sample: m_k counts samples since the latest transition
  task automatic model_edge(input int ic, input int err);
    bit tr, conv;
    m_lv = 0;
    if (!m_armed) begin
      m_armed = 1; m_cur = ic;
      return;
    end
    tr = (ic != m_cur);
    m_cur = ic;
    if (tr && m_tc < 255) m_tc++;
    if (m_track) begin
      if (tr) begin
        record(m_k, 1);
        m_k = 0;
      end else begin
        m_k++;
        m_prev = m_last;
        m_last = err;
`ifdef PST_CONV_STABLE_EN
        conv = (m_k >= 2) && (m_prev <= TOL) && (m_last <= TOL);
        if (conv) begin record(m_k - 1, 0); m_track = 0; end
`else
        conv = (m_last <= TOL);
        if (conv) begin record(m_k, 0); m_track = 0; end
`endif
        else if (m_k == MAXC) begin record(MAXC, 1); m_track = 0; end
      end
    end else if (tr) begin
      m_track = 1; m_k = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".lat_valid"}, lat_valid, m_lv);
    check({tag, ".lat_out"}, lat_out, m_lat);
    check({tag, ".timeout"}, timeout, m_to);
    check({tag, ".busy"}, busy, m_track);
    check({tag, ".trans_count"}, trans_count, m_tc);
    check({tag, ".timeout_count"}, timeout_count, m_toc);
    check({tag, ".sum_lat"}, sum_lat, m_sum);
    check({tag, ".hist_count"}, hist_count, hq.size());
    for (int i = 0; i < DEPTH; i++) begin
      hist_rd_idx = 3'(i);
      #1;
      check({tag, ".hist_rd_data"}, hist_rd_data, (i < hq.size()) ? hq[i] : 9'd0);
    end
  endtask

  task automatic do_edge(input int ic, input int err, input int gap);
    @(negedge clk);
    input_current = 8'(ic);
    error_L2      = 8'(err);
    cycle_start   = 1'b1;
    model_edge(ic, err);
    @(negedge clk);
    cycle_start = 1'b0;
    check_all("edge");
    m_lv = 0;
    @(negedge clk);
    check("lat_valid_clear", lat_valid, m_lv);
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int ic, err;
    model_reset();
    @(negedge clk);
    check_all("por");
    rst = 1'b0;

    // arm only
    do_edge(200, 50, 1);
    check("arm.trans_count", trans_count, 0);

    // 200 -> 5, then 40, 20, 4
    do_edge(5, 50, 0);
    do_edge(5, 40, 1);
    do_edge(5, 20, 2);
    do_edge(5, 4, 0);
`ifndef PST_CONV_STABLE_EN
    check("tp2.lat_out", lat_out, 3);
    hist_rd_idx = 3'd0; #1;
    check("tp2.hist0", hist_rd_data, 9'h003);
    check("tp2.sum_lat", sum_lat, 3);
`endif

    // timeout after MAX_CYC
    do_edge(100, 50, 0);
    for (int j = 0; j < MAXC; j++) do_edge(100, 30, j % 3);
`ifndef PST_CONV_STABLE_EN
    check("tp3.lat_out", lat_out, 16);
    check("tp3.timeout", timeout, 1);
    check("tp3.timeout_count", timeout_count, 1);
    check("tp3.busy", busy, 0);
`endif

    // abort then converge
    do_edge(50, 50, 0);
    do_edge(50, 30, 0);
    do_edge(50, 30, 1);
    do_edge(60, 30, 0);
    check("tp4.lat_out", lat_out, 2);
    check("tp4.timeout", timeout, 1);
    check("tp4.busy", busy, 1);
    do_edge(60, 0, 0);
    do_edge(60, 0, 0);

    // stable-confirm pattern 4,30,3,2
    do_edge(70, 50, 0);
    do_edge(70, 4, 0);
    do_edge(70, 30, 0);
    do_edge(70, 3, 0);
    do_edge(70, 2, 0);
`ifdef PST_CONV_STABLE_EN
    check("stable.lat_out", lat_out, 3);
    check("stable.timeout", timeout, 0);
`endif

    // ten converged transitions from a clean reset
    do_reset();
    do_edge(20, 50, 0);
    for (int i = 1; i <= 10; i++) begin
      do_edge(20 + i, 50, 0);
      for (int j = 1; j < i; j++) do_edge(20 + i, 30, 0);
      do_edge(20 + i, 0, 0);
      do_edge(20 + i, 0, 0);
    end
`ifndef PST_CONV_STABLE_EN
    check("tp5.hist_count", hist_count, 8);
    hist_rd_idx = 3'd0; #1;
    check("tp5.hist0", hist_rd_data, 9'd10);
    hist_rd_idx = 3'd7; #1;
    check("tp5.hist7", hist_rd_data, 9'd3);
    check("tp5.sum_lat", sum_lat, 55);
`endif

    // reset while a measurement is in flight
    do_edge(99, 50, 0);
    do_edge(99, 30, 0);
    check("tp6.busy", busy, 1);
    do_reset();
    repeat (2) begin
      @(negedge clk);
      check("tp6.no_pulse", lat_valid, 0);
    end

    // randomized run
    ic = 0;
    for (int n = 0; n < 900; n++) begin
      if ($urandom_range(0, 2) == 0) ic = $urandom_range(0, 255);
      if ($urandom_range(0, 3) == 0) err = $urandom_range(0, TOL);
      else err = $urandom_range(TOL + 1, 255);
      do_edge(ic, err, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pst_conv_monitor.md
Name: pst_conv_monitor

Overview:
- Downstream observer of pst_2layer; sits beside gamma_oscillator on the same cycle_start/clk domain.
- Detects input-current transitions at gamma-cycle boundaries and counts gamma cycles until error_L2 falls within tolerance.
- Logs each latency or timeout into a circular history and keeps running statistics, so benches and on-chip debug read convergence figures without hand-counting.

Parameters:
TOL, 8'd5, error_L2 value at or below which the layer counts as converged
MAX_CYC, 8'd16, gamma cycles after a transition before a timeout is declared; legal range 1..255
HIST_DEPTH, 8, history entries; power of two, 2..16
HIST_AW, 3, log2(HIST_DEPTH)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
cycle_start  in  1  one-clk pulse from gamma_oscillator
input_current  in  8  current driving pst_2layer L1
error_L2  in  8  pst_2layer error_L2; sampled only on cycle_start
busy  out  1  a measurement is in flight
lat_valid  out  1  one-clk pulse; a new record was written
lat_out  out  8  latency of the newest record, in gamma cycles
timeout  out  1  newest record is a timeout or an abort
trans_count  out  8  transitions detected; saturates at 255
timeout_count  out  8  timeout plus abort records; saturates at 255
sum_lat  out  16  sum of all recorded lat values; saturates at 65535
hist_count  out  HIST_AW+1  valid history entries; saturates at HIST_DEPTH
hist_rd_idx  in  HIST_AW  history read index; 0 = newest
hist_rd_data  out  9  {timeout, lat} of the selected entry; combinational; 0 when hist_rd_idx >= hist_count

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high. All state changes occur on posedge clk, and only in clocks where cycle_start=1 (the "sample edge"), except for the lat_valid clear.
- Reset values: every output and register is 0, the FSM is IDLE, the armed flag is 0, and cur_q is 0.
- The first sample edge after reset only loads cur_q = input_current and sets armed=1. No transition is detected at that edge.
- Transition: at a sample edge with armed=1 and input_current != cur_q. cur_q <= input_current at every sample edge.
- FSM:
  - IDLE, transition at a sample edge: cnt <= 0, trans_count++, go to TRACK, busy <= 1.
  - TRACK, sample edge without a transition:
    - cnt_n = cnt + 1.
    - If error_L2 <= TOL: record (lat = cnt_n, timeout = 0) and go to IDLE.
    - Else if cnt_n == MAX_CYC: record (lat = MAX_CYC, timeout = 1) and go to IDLE.
    - Else: cnt <= cnt_n and stay in TRACK.
  - TRACK, sample edge with a transition (abort): record (lat = cnt, timeout = 1), cnt <= 0, trans_count++, stay in TRACK. The abort takes priority over the convergence check at that edge.
- Convergence is never checked at the transition edge itself, so the minimum latency is 1.
- Record action, all at the same edge:
  - lat_out and timeout are updated; lat_valid <= 1 for exactly one clk.
  - The history entry is written at wr_ptr, and wr_ptr increments modulo HIST_DEPTH. When the buffer is full the oldest entry is overwritten.
  - hist_count increments, saturating at HIST_DEPTH.
  - sum_lat += lat (saturating); timeout_count++ if timeout=1 (saturating).
- History read: entry = mem[(wr_ptr - 1 - hist_rd_idx) mod HIST_DEPTH].
- busy = (state == TRACK).
- Arithmetic is unsigned. Saturation is checked before the add.
- rst asserted mid-measurement clears everything immediately. The in-flight measurement is lost and no record is written.
- cycle_start is assumed never to occur on consecutive clocks. The logic must not depend on cycle_start occurring in any particular clk of the gamma cycle.

Optional Feature:
- Macro: PST_CONV_STABLE_EN.
- When defined:
  - Convergence requires error_L2 <= TOL at two consecutive TRACK sample edges.
  - The recorded lat is the cycle count of the first of the two edges.
  - A pending first hit that is followed by error > TOL is discarded.
  - Timeout still fires when cnt_n == MAX_CYC and no confirmed pair exists. A first hit landing exactly on MAX_CYC is a timeout.
- When undefined: single-sample convergence as specified above.

Test Plan:
- Reset, then input_current=200 held and error_L2=50 -> after the first sample edge armed=1, trans_count=0, busy=0.
- Input 200->5 with error_L2=40,20,4 on the next three sample edges -> lat_valid pulses once, lat_out=3, timeout=0, hist_rd_data(idx0)=9'h003, sum_lat=3.
- Transition followed by error_L2=30 held for 16 edges -> lat_out=16, timeout=1, timeout_count=1, busy drops at the 16th edge.
- Transition, error_L2=30 for 2 edges, then a second input change -> abort record lat=2 with timeout=1, busy stays 1, trans_count=2; error_L2=0 at the next edge -> record lat=1.
- Ten converged transitions with lat=1..10 -> hist_count=8, idx0 returns lat 10, idx7 returns lat 3, sum_lat=55.
- With PST_CONV_STABLE_EN defined: error sequence 4,30,3,2 -> single record lat=3. rst pulsed while busy=1 -> all outputs 0 and no lat_valid pulse.
